// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with 2-bit saturating counters.
// Optional lookup/mispredict statistics are compiled in with `define BP_STATS_EN.
module branch_predictor #(
  parameter  int IDX_BITS = 6,
  localparam int TAG_BITS = 30 - IDX_BITS,
  localparam int ENTRIES  = 1 << IDX_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lookEnable,
  input  logic [31:0] lookPc,
  output logic        predValid,
  output logic        predTaken,
  output logic [31:0] predTarget,
  input  logic        updEnable,
  input  logic [31:0] updPc,
  input  logic        updTaken,
  input  logic [31:0] updTarget,
  input  logic        updPredTaken,
  output logic [31:0] statLookups,
  output logic [31:0] statMispred
);

  // predValid is a one-cycle pulse with no back-pressure: a lookup sampled at
  // edge N is answered after edge N; predTaken/predTarget hold between pulses.

  logic                r_valid  [ENTRIES];
  logic [TAG_BITS-1:0] r_tag    [ENTRIES];
  logic [31:0]         r_target [ENTRIES];
  logic [1:0]          r_ctr    [ENTRIES];

  logic        r_pred_valid;
  logic        r_pred_taken;
  logic [31:0] r_pred_target;

  logic [IDX_BITS-1:0] w_look_idx;
  logic [TAG_BITS-1:0] w_look_tag;
  logic                w_look_hit;
  logic                w_look_taken;
  logic [31:0]         w_look_target;
  logic [IDX_BITS-1:0] w_upd_idx;
  logic [TAG_BITS-1:0] w_upd_tag;
  logic                w_upd_hit;
  logic                w_unused_bits;

  assign w_look_idx    = lookPc[IDX_BITS+1:2];
  assign w_look_tag    = lookPc[31:IDX_BITS+2];
  assign w_look_hit    = r_valid[w_look_idx] && (r_tag[w_look_idx] == w_look_tag);
  assign w_look_taken  = w_look_hit && r_ctr[w_look_idx][1];
  assign w_look_target = w_look_taken ? r_target[w_look_idx] : lookPc + 32'd4;

  assign w_upd_idx = updPc[IDX_BITS+1:2];
  assign w_upd_tag = updPc[31:IDX_BITS+2];
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  // Lookup reads the table before this edge's update commits (read-before-write).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pred_valid  <= 1'b0;
      r_pred_taken  <= 1'b0;
      r_pred_target <= 32'd0;
    end else begin
      r_pred_valid <= lookEnable;
      if (lookEnable) begin
        r_pred_taken  <= w_look_taken;
        r_pred_target <= w_look_target;
      end
    end
  end

  assign predValid  = r_pred_valid;
  assign predTaken  = r_pred_taken;
  assign predTarget = r_pred_target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= 32'd0;
        r_ctr[i]    <= 2'b01;
      end
    end else if (updEnable) begin
      if (w_upd_hit) begin
        if (updTaken) begin
          if (r_ctr[w_upd_idx] != 2'b11) r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + 2'd1;
          r_target[w_upd_idx] <= updTarget;
        end else if (r_ctr[w_upd_idx] != 2'b00) begin
          r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - 2'd1;
        end
      end else if (updTaken) begin
        // Only taken branches allocate; the previous occupant is simply evicted.
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= updTarget;
        r_ctr[w_upd_idx]    <= 2'b10;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] r_stat_lookups;
  logic [31:0] r_stat_mispred;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_lookups <= 32'd0;
      r_stat_mispred <= 32'd0;
    end else begin
      if (lookEnable) r_stat_lookups <= r_stat_lookups + 32'd1;
      if (updEnable && (updPredTaken != updTaken)) r_stat_mispred <= r_stat_mispred + 32'd1;
    end
  end

  assign statLookups   = r_stat_lookups;
  assign statMispred   = r_stat_mispred;
  assign w_unused_bits = ^{lookPc[1:0], updPc[1:0]};
`else
  assign statLookups   = 32'd0;
  assign statMispred   = 32'd0;
  assign w_unused_bits = ^{lookPc[1:0], updPc[1:0], updPredTaken};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed test-plan cases with literal expectations,
// then random traffic checked every cycle against a behavioural table model.
module tb_branch_predictor;

  localparam int IDX_BITS = 6;
  localparam int ENTRIES  = 1 << IDX_BITS;
`ifdef BP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        lookEnable, updEnable, updTaken, updPredTaken;
  logic [31:0] lookPc, updPc, updTarget;
  logic        predValid, predTaken;
  logic [31:0] predTarget, statLookups, statMispred;

  branch_predictor #(.IDX_BITS(IDX_BITS)) dut (
    .clk(clk), .rst(rst),
    .lookEnable(lookEnable), .lookPc(lookPc),
    .predValid(predValid), .predTaken(predTaken), .predTarget(predTarget),
    .updEnable(updEnable), .updPc(updPc), .updTaken(updTaken),
    .updTarget(updTarget), .updPredTaken(updPredTaken),
    .statLookups(statLookups), .statMispred(statMispred)
  );

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Table kept as plain arrays indexed by arithmetic on the PC; ctr is an int 0..3.
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  logic [31:0] m_tgt    [ENTRIES];
  int          m_ctr    [ENTRIES];
  logic        exp_valid, exp_taken;
  logic [31:0] exp_target, exp_lookups, exp_mispred;

  function automatic int pc_idx(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int unsigned pc_tag(input logic [31:0] pc);
    return int'(pc >> (IDX_BITS + 2));
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[pc_idx(pc)] && (m_tag[pc_idx(pc)] == pc_tag(pc));
  endfunction

  function automatic bit m_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[pc_idx(pc)] >= 2);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_valid   <= 1'b0;
      exp_taken   <= 1'b0;
      exp_target  <= 32'd0;
      exp_lookups <= 32'd0;
      exp_mispred <= 32'd0;
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] <= 1'b0;
        m_ctr[i]   <= 1;
      end
    end else begin
      exp_valid <= lookEnable;
      if (lookEnable) begin
        exp_taken   <= m_taken(lookPc);
        exp_target  <= m_taken(lookPc) ? m_tgt[pc_idx(lookPc)] : lookPc + 32'd4;
        exp_lookups <= exp_lookups + 32'd1;
      end
      if (updEnable) begin
        if (updPredTaken != updTaken) exp_mispred <= exp_mispred + 32'd1;
        if (m_hit(updPc)) begin
          if (updTaken) begin
            m_ctr[pc_idx(updPc)] <= (m_ctr[pc_idx(updPc)] == 3) ? 3 : m_ctr[pc_idx(updPc)] + 1;
            m_tgt[pc_idx(updPc)] <= updTarget;
          end else begin
            m_ctr[pc_idx(updPc)] <= (m_ctr[pc_idx(updPc)] == 0) ? 0 : m_ctr[pc_idx(updPc)] - 1;
          end
        end else if (updTaken) begin
          m_valid[pc_idx(updPc)] <= 1'b1;
          m_tag[pc_idx(updPc)]   <= pc_tag(updPc);
          m_tgt[pc_idx(updPc)]   <= updTarget;
          m_ctr[pc_idx(updPc)]   <= 2;
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (check_en && !rst) begin
      chk("cyc_predValid", {31'd0, predValid}, {31'd0, exp_valid});
      chk("cyc_predTaken", {31'd0, predTaken}, {31'd0, exp_taken});
      chk("cyc_predTarget", predTarget, exp_target);
      chk("cyc_statLookups", statLookups, STATS ? exp_lookups : 32'd0);
      chk("cyc_statMispred", statMispred, STATS ? exp_mispred : 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; inputs are sampled at the next rising edge and
  // the task returns at the following falling edge with outputs settled.
  task automatic cycle(input bit le, input logic [31:0] lpc, input bit ue,
                       input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
                       input bit upt);
    lookEnable = le; lookPc = lpc;
    updEnable = ue; updPc = upc; updTaken = ut; updTarget = utgt; updPredTaken = upt;
    @(negedge clk);
    lookEnable = 1'b0; updEnable = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    cycle(1'b1, pc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] pc, input bit t, input logic [31:0] tgt);
    cycle(1'b0, 32'd0, 1'b1, pc, t, tgt, 1'b0);
  endtask

  task automatic expect_pred(input string name, input bit t, input logic [31:0] tgt);
    chk({name, "_valid"}, {31'd0, predValid}, 32'd1);
    chk({name, "_taken"}, {31'd0, predTaken}, {31'd0, t});
    chk({name, "_target"}, predTarget, tgt);
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 19) == 0) return 32'hFFFF_FFFC;
    return 32'h0040_0000 | (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 5)) << 2);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    lookEnable = 1'b0; lookPc = 32'd0;
    updEnable = 1'b0; updPc = 32'd0; updTaken = 1'b0; updTarget = 32'd0; updPredTaken = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_predValid", {31'd0, predValid}, 32'd0);
    chk("rst_predTaken", {31'd0, predTaken}, 32'd0);
    chk("rst_predTarget", predTarget, 32'd0);
    chk("rst_statLookups", statLookups, 32'd0);
    chk("rst_statMispred", statMispred, 32'd0);
    check_en = 1'b1;

    look(32'h0040_0010);
    expect_pred("cold", 1'b0, 32'h0040_0014);

    upd(32'h0040_0010, 1'b1, 32'h0040_0100);
    look(32'h0040_0010);
    expect_pred("alloc", 1'b1, 32'h0040_0100);
    upd(32'h0040_0010, 1'b0, 32'h0);
    upd(32'h0040_0010, 1'b0, 32'h0);
    look(32'h0040_0010);
    expect_pred("two_nt", 1'b0, 32'h0040_0014);

    repeat (4) upd(32'h0040_0010, 1'b1, 32'h0040_0100);
    upd(32'h0040_0010, 1'b0, 32'h0);
    look(32'h0040_0010);
    expect_pred("sat_one_nt", 1'b1, 32'h0040_0100);
    upd(32'h0040_0010, 1'b0, 32'h0);
    look(32'h0040_0010);
    expect_pred("sat_two_nt", 1'b0, 32'h0040_0014);

    upd(32'h0040_0010, 1'b1, 32'h0040_0100);
    upd(32'h0040_1010, 1'b1, 32'h0040_0200);
    look(32'h0040_0010);
    expect_pred("alias_old", 1'b0, 32'h0040_0014);
    look(32'h0040_1010);
    expect_pred("alias_new", 1'b1, 32'h0040_0200);

    cycle(1'b1, 32'h0040_0010, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0300, 1'b0);
    expect_pred("rbw_same", 1'b0, 32'h0040_0014);
    look(32'h0040_0010);
    expect_pred("rbw_next", 1'b1, 32'h0040_0300);

    look(32'hFFFF_FFFC);
    expect_pred("wrap", 1'b0, 32'h0000_0000);

    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) < 7, rand_pc(), $urandom_range(0, 9) < 5, rand_pc(),
            1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
    end

    // Statistics from a clean reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 32'h0040_0010, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0);
    cycle(1'b1, 32'h0040_0020, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b1);
    look(32'h0040_0030);
    chk("stat_lookups", statLookups, STATS ? 32'd3 : 32'd0);
    chk("stat_mispred", statMispred, STATS ? 32'd1 : 32'd0);

    // Asynchronous reset with a lookup in flight.
    lookEnable = 1'b1; lookPc = 32'h0040_0010;
    @(posedge clk);
    #2;
    lookEnable = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_predValid", {31'd0, predValid}, 32'd0);
    chk("async_predTaken", {31'd0, predTaken}, 32'd0);
    chk("async_predTarget", predTarget, 32'd0);
    chk("async_statLookups", statLookups, 32'd0);
    chk("async_statMispred", statMispred, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("async_no_pulse", {31'd0, predValid}, 32'd0);
    look(32'h0040_0010);
    expect_pred("after_async", 1'b0, 32'h0040_0014);

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage branch predictor and branch target buffer for the pipelined MIPS core. It sits at the opposite end of the branch-resolution path from the execute-stage `Branch` comparator. It consumes the resolved `takeBranch` outcome and target through an update port, trains a direct-mapped table of 2-bit saturating counters, and returns a registered taken/not-taken prediction and next-PC for each fetch lookup.

## Interface
Parameters:
- `IDX_BITS`, default 6: table index width; the table has 2^IDX_BITS entries.
- `TAG_BITS`, derived as 30 − IDX_BITS: tag width, from pc[31:IDX_BITS+2].

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `lookEnable`  in  1  fetch lookup request this cycle.
- `lookPc`  in  32  fetch PC; word aligned, bits [1:0] ignored.
- `predValid`  out  1  one-cycle pulse: a prediction for the previous cycle's lookup is presented.
- `predTaken`  out  1  predicted direction.
- `predTarget`  out  32  predicted next PC.
- `updEnable`  in  1  a resolved branch is reported from execute.
- `updPc`  in  32  PC of the resolved branch.
- `updTaken`  in  1  actual outcome (the execute-stage `takeBranch`).
- `updTarget`  in  32  actual branch target.
- `updPredTaken`  in  1  the prediction that was made for this branch; used only for statistics.
- `statLookups`  out  32  lookup count (BP_STATS_EN only).
- `statMispred`  out  32  mispredict count (BP_STATS_EN only).

## Operation
- Address split: index = pc[IDX_BITS+1:2]; tag = pc[31:IDX_BITS+2].
- Each entry holds `valid`, `tag`, `target[31:0]` and `ctr[1:0]`.
  - Counter encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
- Reset clears every entry to valid=0 and ctr=01.
- Lookup:
  - hit = valid && tag match.
  - predTaken = hit && ctr[1].
  - predTarget = target if predTaken, otherwise lookPc+4 (32-bit wrap, so 0xFFFFFFFC+4 = 0).
- Update on hit:
  - updTaken=1: ctr saturating +1 (11 stays 11); target ← updTarget.
  - updTaken=0: ctr saturating −1 (00 stays 00); target unchanged.
- Update on miss:
  - updTaken=1: allocate the entry, overwriting any existing one. Set valid=1, tag, target=updTarget, ctr=10.
  - updTaken=0: no change. Not-taken branches never allocate.
- Same-cycle lookup and update to the same index: the lookup reads pre-update state (read-before-write). The update still commits at that edge.
- Two updates cannot collide because there is one update port; back-to-back updates to the same entry each apply in order.

## Timing
- Lookup latency is 1 cycle. Inputs are sampled at edge N; predValid, predTaken and predTarget are valid after edge N.
  - predValid = lookEnable registered.
  - predTaken and predTarget hold their last values while predValid=0.
- Update latency is 1 cycle. An update sampled at edge N is visible to a lookup sampled at edge N+1.
- Reset values: predValid=0, predTaken=0, predTarget=0, statLookups=0, statMispred=0.
- Reset asserted mid-operation clears all outputs and the table immediately, with no clock edge needed.
  - A lookup in flight is dropped: no predValid pulse follows reset deassertion.

## Configuration
- `BP_STATS_EN` defined:
  - statLookups increments on each sampled lookEnable.
  - statMispred increments on each sampled updEnable with updPredTaken ≠ updTaken.
  - Both are 32-bit counters that wrap from 0xFFFFFFFF to 0.
- `BP_STATS_EN` undefined: both counters are absent from the logic and the ports are tied to 0.

## Test plan
- Reset, then lookPc=0x00400010 → next cycle predValid=1, predTaken=0, predTarget=0x00400014.
- Update pc=0x00400010, taken=1, target=0x00400100, then look it up → predTaken=1, predTarget=0x00400100. Follow with two not-taken updates → lookup gives predTaken=0, predTarget=0x00400014.
- Four taken updates to the same PC (ctr stays 11), then one not-taken → still predTaken=1. A second not-taken → predTaken=0.
- Aliasing: train 0x00400010 taken, then update 0x00401010 taken (same index at IDX_BITS=6, different tag). Looking up 0x00400010 → miss, predTaken=0.
- Lookup and update of the same PC in the same cycle → prediction reflects old state. A repeat lookup one cycle later reflects the new state.
- With BP_STATS_EN: 3 lookups plus updates (predTaken=0, taken=1) and (1, 1) → statLookups=3, statMispred=1. Assert rst mid-stream → all counters and outputs return to 0 asynchronously.
